sdram_rom_loader: RTL and testbench

Sequencer that takes the byte-wide ROM download stream from the MiST data_io block and writes it into the shared SDRAM through the controller's two toggle-handshake request ports. Bytes are packed into 16-bit words. Each word is routed by download address: port 1 serves banks 0/1 (CPU/tile ROMs), port 2 serves banks 2/3 (sprite ROMs). While a write is outstanding, the loader back-pressures the download, and it flags completion so the core can release reset.

---
 rtl/sdram_loader_pkg.sv | 38 +++
 rtl/sdram_req_port.sv | 48 ++++
 rtl/sdram_rom_loader.sv | 242 ++++++++++++++++++++++++
 tb/tb_sdram_rom_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_loader_pkg.sv
// Shared types and constants for the SDRAM ROM loader.
// Holds the sequencer state encoding, byte-strobe codes, port-select encoding
// and the address routing helpers that map a download byte address onto a port.
package sdram_loader_pkg;

   // First download byte address that belongs to the sprite region (even).
   localparam logic [24:0] SP_START = 25'h0A000;

   localparam logic [1:0] DS_WORD = 2'b11;
   localparam logic [1:0] DS_LO   = 2'b01;
   localparam logic [1:0] DS_HI   = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      ISSUE,
      WAIT_ACK,
      DONE
   } state_t;

   typedef enum logic {
      SEL_PORT1 = 1'b0,   // banks 0/1: CPU and tile ROMs
      SEL_PORT2 = 1'b1    // banks 2/3: sprite ROMs
   } port_sel_t;

   function automatic port_sel_t route_sel(input logic [24:0] addr);
      return (addr < SP_START) ? SEL_PORT1 : SEL_PORT2;
   endfunction

   // Sprite addresses are rebased to the start of their bank pair; the
   // 25-bit difference is deliberately truncated to the 23-bit word address.
   function automatic logic [22:0] route_addr(input logic [24:0] addr);
      logic [24:0] off;
      off = (addr < SP_START) ? addr : (addr - SP_START);
      return off[23:1];
   endfunction

endpackage

// File: rtl/sdram_req_port.sv
// One toggle-handshake write request port towards the SDRAM controller.
// Latency: issue pulse -> req toggle and a/d/ds update on the same clock edge.
// Backpressure: busy stays high from the toggle until the registered ack matches req.
//
// Ports: clk, reset (sync, active-high); ack from controller; issue pulse with
// wr_a/wr_d/wr_ds payload; req/a/d/ds to controller; busy to the sequencer.
module sdram_req_port
   import sdram_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        ack,
   input  logic        issue,
   input  logic [22:0] wr_a,
   input  logic [15:0] wr_d,
   input  logic [1:0]  wr_ds,
   output logic        req,
   output logic [22:0] a,
   output logic [15:0] d,
   output logic [1:0]  ds,
   output logic        busy
);

   logic ack_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         // Aligning req to ack means the controller sees no request after reset.
         req   <= ack;
         ack_q <= ack;
         a     <= '0;
         d     <= '0;
         ds    <= DS_WORD;
      end else begin
         ack_q <= ack;
         if (issue) begin
            req <= ~req;
            a   <= wr_a;
            d   <= wr_d;
            ds  <= wr_ds;
         end
      end
   end

   // Ack is compared in its registered form, so busy clears one cycle after the echo.
   assign busy = req ^ ack_q;

endmodule

// File: rtl/sdram_rom_loader.sv
// Packs the byte-wide ROM download into 16-bit SDRAM writes routed to port 1 or 2.
// Latency: byte completing a word -> req toggle at the edge ending the next cycle.
// Backpressure: ioctl_wait high while a write is in flight or a latched byte is pending.
//
// Ports: clk, reset (sync, active-high); ioctl_downl/wr/addr/dout download input,
// ioctl_wait stall; port1_*/port2_* toggle request ports; rom_loaded completion level.
module sdram_rom_loader
   import sdram_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        ioctl_downl,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic        port1_req,
   input  logic        port1_ack,
   output logic        port1_we,
   output logic [22:0] port1_a,
   output logic [1:0]  port1_ds,
   output logic [15:0] port1_d,
   output logic        port2_req,
   input  logic        port2_ack,
   output logic        port2_we,
   output logic [22:0] port2_a,
   output logic [1:0]  port2_ds,
   output logic [15:0] port2_d,
   output logic        rom_loaded
);

   state_t      state, state_n;
   logic        downl_q;
   logic        restart, restart_n;
   logic        held_vld, held_vld_n;
   logic [24:0] held_addr, held_addr_n;
   logic [7:0]  held_dat, held_dat_n;
   logic        pend_vld, pend_vld_n;
   logic [24:0] pend_addr, pend_addr_n;
   logic [7:0]  pend_dat, pend_dat_n;
   port_sel_t   iss_sel, iss_sel_n;
   logic [22:0] iss_a, iss_a_n;
   logic [15:0] iss_d, iss_d_n;
   logic [1:0]  iss_ds, iss_ds_n;

   logic        p1_issue, p2_issue, p1_busy, p2_busy, busy;
   logic        rise;
   logic        cur_vld, same_word, do_issue;
   logic [24:0] cur_addr, src_addr;
   logic [7:0]  cur_dat;
   logic [15:0] src_d;
   logic [1:0]  src_ds;

   assign rise = ioctl_downl & ~downl_q;
   assign busy = p1_busy | p2_busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         downl_q   <= 1'b0;
         restart   <= 1'b0;
         held_vld  <= 1'b0;
         held_addr <= '0;
         held_dat  <= '0;
         pend_vld  <= 1'b0;
         pend_addr <= '0;
         pend_dat  <= '0;
         iss_sel   <= SEL_PORT1;
         iss_a     <= '0;
         iss_d     <= '0;
         iss_ds    <= DS_WORD;
      end else begin
         state     <= state_n;
         downl_q   <= ioctl_downl;
         restart   <= restart_n;
         held_vld  <= held_vld_n;
         held_addr <= held_addr_n;
         held_dat  <= held_dat_n;
         pend_vld  <= pend_vld_n;
         pend_addr <= pend_addr_n;
         pend_dat  <= pend_dat_n;
         iss_sel   <= iss_sel_n;
         iss_a     <= iss_a_n;
         iss_d     <= iss_d_n;
         iss_ds    <= iss_ds_n;
      end
   end

   always_comb begin
      state_n     = state;
      restart_n   = restart;
      held_vld_n  = held_vld;
      held_addr_n = held_addr;
      held_dat_n  = held_dat;
      pend_vld_n  = pend_vld;
      pend_addr_n = pend_addr;
      pend_dat_n  = pend_dat;
      iss_sel_n   = iss_sel;
      iss_a_n     = iss_a;
      iss_d_n     = iss_d;
      iss_ds_n    = iss_ds;
      p1_issue    = 1'b0;
      p2_issue    = 1'b0;
      do_issue    = 1'b0;
      src_addr    = '0;
      src_d       = '0;
      src_ds      = DS_WORD;

      // A byte deferred behind a flush is re-evaluated before new input;
      // the source is stalled while it exists, so the two never collide.
      cur_vld   = pend_vld | ioctl_wr;
      cur_addr  = pend_vld ? pend_addr : ioctl_addr;
      cur_dat   = pend_vld ? pend_dat  : ioctl_dout;
      same_word = (held_addr[24:1] == cur_addr[24:1]);

      case (state)
         IDLE, DONE: begin
            if (rise) begin
               state_n    = COLLECT;
               restart_n  = 1'b0;
               held_vld_n = 1'b0;
               pend_vld_n = 1'b0;
            end
         end

         COLLECT: begin
            if (rise) begin
               held_vld_n = 1'b0;
               pend_vld_n = 1'b0;
            end else if (cur_vld) begin
               pend_vld_n = 1'b0;
               if (held_vld && !same_word) begin
                  // Flush the lone low byte, keep the new byte for later.
                  do_issue    = 1'b1;
                  src_addr    = held_addr;
                  src_d       = {8'h00, held_dat};
                  src_ds      = DS_LO;
                  held_vld_n  = 1'b0;
                  pend_vld_n  = 1'b1;
                  pend_addr_n = cur_addr;
                  pend_dat_n  = cur_dat;
               end else if (!cur_addr[0]) begin
                  held_vld_n  = 1'b1;
                  held_addr_n = cur_addr;
                  held_dat_n  = cur_dat;
               end else if (held_vld) begin
                  do_issue   = 1'b1;
                  src_addr   = cur_addr;
                  src_d      = {cur_dat, held_dat};
                  src_ds     = DS_WORD;
                  held_vld_n = 1'b0;
               end else begin
                  do_issue = 1'b1;
                  src_addr = cur_addr;
                  src_d    = {cur_dat, 8'h00};
                  src_ds   = DS_HI;
               end
            end else if (!ioctl_downl) begin
               if (held_vld) begin
                  do_issue   = 1'b1;
                  src_addr   = held_addr;
                  src_d      = {8'h00, held_dat};
                  src_ds     = DS_LO;
                  held_vld_n = 1'b0;
               end else begin
                  state_n = DONE;
               end
            end
         end

         ISSUE: begin
            p1_issue = (iss_sel == SEL_PORT1);
            p2_issue = (iss_sel == SEL_PORT2);
            if (rise) restart_n = 1'b1;
            state_n = WAIT_ACK;
         end

         WAIT_ACK: begin
            if (rise) restart_n = 1'b1;
            if (!busy) begin
               if (restart || rise) begin
                  // New download began mid-write: drop whatever was collected.
                  restart_n  = 1'b0;
                  held_vld_n = 1'b0;
                  pend_vld_n = 1'b0;
                  state_n    = COLLECT;
               end else if (!ioctl_downl && !held_vld && !pend_vld) begin
                  state_n = DONE;
               end else begin
                  state_n = COLLECT;
               end
            end
         end

         default: state_n = IDLE;
      endcase

      if (do_issue) begin
         iss_sel_n = route_sel(src_addr);
         iss_a_n   = route_addr(src_addr);
         iss_d_n   = src_d;
         iss_ds_n  = src_ds;
         state_n   = ISSUE;
      end
   end

   assign ioctl_wait = (state == ISSUE) || (state == WAIT_ACK) || pend_vld;
   assign rom_loaded = (state == DONE);
   assign port1_we   = 1'b1;
   assign port2_we   = 1'b1;

   sdram_req_port u_port1 (
      .clk   (clk),
      .reset (reset),
      .ack   (port1_ack),
      .issue (p1_issue),
      .wr_a  (iss_a),
      .wr_d  (iss_d),
      .wr_ds (iss_ds),
      .req   (port1_req),
      .a     (port1_a),
      .d     (port1_d),
      .ds    (port1_ds),
      .busy  (p1_busy)
   );

   sdram_req_port u_port2 (
      .clk   (clk),
      .reset (reset),
      .ack   (port2_ack),
      .issue (p2_issue),
      .wr_a  (iss_a),
      .wr_d  (iss_d),
      .wr_ds (iss_ds),
      .req   (port2_req),
      .a     (port2_a),
      .d     (port2_d),
      .ds    (port2_ds),
      .busy  (p2_busy)
   );

endmodule

// File: tb/tb_sdram_rom_loader.sv
// Self-checking bench for sdram_rom_loader: word-level reference model feeding a
// scoreboard queue, a behavioural controller per port that pops and compares
// each request and answers it after a random or deliberately long delay.
module tb_sdram_rom_loader;

   localparam logic [24:0] SP = 25'h0A000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ioctl_downl = 1'b0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic        ioctl_wait;
   logic        port1_req, port2_req;
   logic        port1_ack = 1'b1;
   logic        port2_ack = 1'b0;
   logic        port1_we, port2_we;
   logic [22:0] port1_a, port2_a;
   logic [1:0]  port1_ds, port2_ds;
   logic [15:0] port1_d, port2_d;
   logic        rom_loaded;

   always #5 clk = ~clk;

   sdram_rom_loader dut (
      .clk(clk), .reset(reset),
      .ioctl_downl(ioctl_downl), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
      .port1_req(port1_req), .port1_ack(port1_ack), .port1_we(port1_we),
      .port1_a(port1_a), .port1_ds(port1_ds), .port1_d(port1_d),
      .port2_req(port2_req), .port2_ack(port2_ack), .port2_we(port2_we),
      .port2_a(port2_a), .port2_ds(port2_ds), .port2_d(port2_d),
      .rom_loaded(rom_loaded)
   );

   typedef struct {
      int          port;
      logic [22:0] a;
      logic [15:0] d;
      logic [1:0]  ds;
   } wr_t;

   wr_t exp_q[$];
   int  n_pass = 0;
   int  n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference: one SDRAM write per downloaded word, bytes that were not sent are not strobed.
   function automatic wr_t model(input logic [24:0] waddr, input int kind,
                                 input logic [7:0] lo, input logic [7:0] hi);
      wr_t w;
      longint off;
      logic has_lo, has_hi;
      has_lo = (kind != 2);
      has_hi = (kind != 1);
      if (waddr < SP) begin w.port = 1; off = waddr; end
      else begin w.port = 2; off = longint'(waddr) - longint'(SP); end
      w.a  = 23'((off / 2) % (longint'(1) << 23));
      w.ds = {has_hi, has_lo};
      w.d  = {has_hi ? hi : 8'h00, has_lo ? lo : 8'h00};
      return w;
   endfunction

   function automatic logic get_req(input int p);
      return (p == 1) ? port1_req : port2_req;
   endfunction

   function automatic logic get_ack(input int p);
      return (p == 1) ? port1_ack : port2_ack;
   endfunction

   // Behavioural SDRAM controller for one port.
   task automatic ctrl(input int p);
      forever begin
         @(posedge clk); #1;
         if (reset === 1'b0 && get_req(p) !== get_ack(p)) begin
            logic        r0, other_busy, stable;
            logic [22:0] a0;
            logic [15:0] d0, mask;
            logic [1:0]  ds0;
            int          dly;
            wr_t         e;
            r0  = get_req(p);
            a0  = (p == 1) ? port1_a  : port2_a;
            d0  = (p == 1) ? port1_d  : port2_d;
            ds0 = (p == 1) ? port1_ds : port2_ds;
            other_busy = (p == 1) ? (port2_req !== port2_ack) : (port1_req !== port1_ack);
            chk("one_outstanding", other_busy, 0);
            dly = $urandom_range(6, 12);
            if (exp_q.size() == 0) begin
               chk("unexpected_req_port", p, 0);
            end else begin
               e = exp_q.pop_front();
               chk("req_port", p, e.port);
               chk("req_a", a0, e.a);
               chk("req_ds", ds0, e.ds);
               mask = {ds0[1] ? 8'hFF : 8'h00, ds0[0] ? 8'hFF : 8'h00};
               chk("req_d", d0 & mask, e.d);
               if (e.port == 2 && e.a == 23'd1 && e.d == 16'hBBAA) dly = 40;
            end
            stable = 1'b1;
            repeat (dly - 1) begin
               @(posedge clk); #1;
               if (get_req(p) !== r0 || ioctl_wait !== 1'b1) stable = 1'b0;
               if (p == 1 && (port1_a !== a0 || port1_d !== d0 || port1_ds !== ds0)) stable = 1'b0;
               if (p == 2 && (port2_a !== a0 || port2_d !== d0 || port2_ds !== ds0)) stable = 1'b0;
            end
            chk("hold_stable", stable, 1);
            if (p == 1) port1_ack = r0; else port2_ack = r0;
         end
      end
   endtask

   task automatic wait_no_stall();
      int n = 0;
      while (ioctl_wait !== 1'b0 && n < 2000) begin @(posedge clk); #1; n++; end
      if (n >= 2000) chk("stall_timeout", 1, 0);
   endtask

   task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      wait_no_stall();
      ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
      @(posedge clk); #1;
      ioctl_wr = 1'b0;
   endtask

   // kind: 0 both bytes, 1 even byte only, 2 odd byte only
   task automatic send_word(input logic [24:0] waddr, input int kind,
                            input logic [7:0] lo, input logic [7:0] hi);
      exp_q.push_back(model(waddr, kind, lo, hi));
      if (kind != 2) send_byte(waddr, lo);
      if (kind != 1) send_byte(waddr | 25'd1, hi);
   endtask

   task automatic begin_download();
      ioctl_downl = 1'b1;
      @(posedge clk); #1;
      chk("loaded_cleared", rom_loaded, 0);
   endtask

   task automatic end_download(input bit byte_held);
      int n = 0;
      wait_no_stall();
      ioctl_downl = 1'b0;
      if (!byte_held) begin
         chk("loaded_before_fall", rom_loaded, 0);
         @(posedge clk); #1;
         chk("loaded_one_cycle", rom_loaded, 1);
      end else begin
         while (rom_loaded !== 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
         chk("loaded_after_flush", rom_loaded, 1);
      end
      chk("all_writes_seen", exp_q.size(), 0);
   endtask

   task automatic rand_download(input int nw, input bit boundary);
      logic [24:0] prev = 25'h1;
      logic [24:0] wa;
      int kind = 0;
      begin_download();
      for (int i = 0; i < nw; i++) begin
         if (boundary && i < 2) begin
            wa = (i == 0) ? 25'h09FFE : 25'h0A000;
         end else begin
            do begin
               if ($urandom_range(0, 7) == 0) wa = 25'($urandom);
               else wa = 25'($urandom_range(0, 32'h13FFF));
               wa[0] = 1'b0;
            end while (wa == prev);
         end
         kind = $urandom_range(0, 2);
         send_word(wa, kind, 8'($urandom), 8'($urandom));
         prev = wa;
      end
      end_download(kind == 1);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      fork
         ctrl(1);
         ctrl(2);
      join_none

      // Reset with port1_ack high: req must follow ack so no request appears.
      repeat (4) @(posedge clk);
      #1;
      chk("rst_port1_req", port1_req, 1);
      chk("rst_port2_req", port2_req, 0);
      chk("rst_wait", ioctl_wait, 0);
      chk("rst_loaded", rom_loaded, 0);
      chk("rst_port1_ds", port1_ds, 2'b11);
      chk("rst_port2_a", port2_a, 0);
      chk("rst_port1_d", port1_d, 0);
      chk("we_const", {port1_we, port2_we}, 2'b11);
      reset = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk("post_rst_port1_req", port1_req, 1);

      // Directed download: word, sprite word with slow ack, address skip, odd-length end.
      begin_download();
      send_word(25'h000000, 0, 8'h34, 8'h12);
      send_word(25'h00A002, 0, 8'hAA, 8'hBB);
      send_word(25'h000020, 1, 8'h11, 8'h00);
      send_word(25'h000024, 1, 8'h22, 8'h00);
      send_word(25'h000010, 1, 8'h5A, 8'h00);
      end_download(1'b1);

      // Odd-only word then end with nothing held.
      begin_download();
      send_word(25'h000042, 2, 8'h00, 8'hC3);
      end_download(1'b0);

      // Restart mid-write: the pending byte of the old download is dropped.
      begin_download();
      send_word(25'h000100, 1, 8'h77, 8'h00);
      send_byte(25'h000200, 8'h88);
      ioctl_downl = 1'b0;
      @(posedge clk); #1;
      ioctl_downl = 1'b1;
      @(posedge clk); #1;
      send_word(25'h000300, 0, 8'h9A, 8'hBC);
      end_download(1'b0);

      rand_download(30, 1'b1);
      rand_download(30, 1'b0);
      rand_download(30, 1'b0);

      repeat (20) @(posedge clk);
      #1;
      chk("no_leftover", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
